temporizador_irq: RTL and testbench

- Memory-mapped timer peripheral on the CPU data bus. It answers CPU reads and writes at a fixed base address.
- It raises interrupt requests on the controller's interrupt-enable lines and drops each request when the CPU's interrupt-acknowledge vector names that line.
- It holds two independent 16-bit down-counters with a shared prescaler. Its irq outputs wire straight into the CPU's 8-bit int_e vector.

---
 rtl/temporizador_irq_pkg.sv | 21 ++
 rtl/temporizador_irq_contador_recarga.sv | 54 +++++
 rtl/temporizador_irq.sv | 139 +++++++++++++
 tb/tb_temporizador_irq.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/temporizador_irq_pkg.sv
// Register offsets and bit positions shared by the timer peripheral.
// Imported by the top level of temporizador_irq.
package temporizador_irq_pkg;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_STATUS  = 3'd1;
    localparam logic [2:0] OFF_RELOAD0 = 3'd2;
    localparam logic [2:0] OFF_COUNT0  = 3'd3;
    localparam logic [2:0] OFF_RELOAD1 = 3'd4;
    localparam logic [2:0] OFF_COUNT1  = 3'd5;

    localparam int CTRL_EN0 = 0;
    localparam int CTRL_EN1 = 1;
    localparam int CTRL_IE0 = 2;
    localparam int CTRL_IE1 = 3;
    localparam int CTRL_W   = 4;

    localparam int STAT_PEND0 = 0;
    localparam int STAT_PEND1 = 1;

endpackage

// File: rtl/temporizador_irq_contador_recarga.sv
// One 16-bit down-counter with reload value and sticky pending flag.
// Next-state pending is exported so the top can register irq from it.
module contador_recarga (
    input  logic        clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        en,
    input  logic        wr_count,
    input  logic        wr_reload,
    input  logic        clr_pend,
    input  logic [15:0] wdata,
    output logic [15:0] count,
    output logic [15:0] reload,
    output logic        pend,
    output logic        pend_d,
    output logic        expire
);

    logic [15:0] count_d;

    always_comb begin
        expire  = tick & en & (count == 16'd0);
        count_d = count;
        // A CPU write beats both reload and decrement.
        if (wr_count) begin
            count_d = wdata;
        end else if (expire) begin
            count_d = reload;
        end else if (tick && en) begin
            count_d = count - 16'd1;
        end
        pend_d = pend;
        if (expire) begin
            pend_d = 1'b1;
        end else if (clr_pend) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count  <= '0;
            reload <= '0;
            pend   <= 1'b0;
        end else begin
            count <= count_d;
            pend  <= pend_d;
            if (wr_reload) begin
                reload <= wdata;
            end
        end
    end

endmodule

// File: rtl/temporizador_irq.sv
// Memory-mapped dual down-counter timer with shared prescaler.
// irq bits IRQ0/IRQ1 feed the CPU int_e vector; int_a acknowledges.
module temporizador_irq
    import temporizador_irq_pkg::*;
#(
    parameter logic [15:0] BASE  = 16'hFF00,
    parameter int          PRESC = 8,
    parameter int          IRQ0  = 0,
    parameter int          IRQ1  = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] direcciones,
    input  logic [15:0] wdata,
    input  logic        we,
    output logic [15:0] rdata,
    output logic        sel,
    input  logic [7:0]  int_a,
    output logic [7:0]  irq
);

    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PLAST = PW'(PRESC - 1);

    logic [PW-1:0]     presc;
    logic [CTRL_W-1:0] ctrl;
    logic [CTRL_W-1:0] ctrl_d;
    logic [7:0]        irq_d;
    logic [2:0]        off;
    logic              wr;
    logic              run;
    logic              tick;
    logic              wr_status;
    logic              clr0;
    logic              clr1;
    logic [15:0]       count0;
    logic [15:0]       count1;
    logic [15:0]       reload0;
    logic [15:0]       reload1;
    logic              pend0;
    logic              pend1;
    logic              pend0_d;
    logic              pend1_d;
    logic              exp0;
    logic              exp1;
    logic              unused_bits;

    assign sel       = (direcciones[15:3] == BASE[15:3]);
    assign off       = direcciones[2:0];
    assign wr        = we & sel;
    assign run       = ctrl[CTRL_EN0] | ctrl[CTRL_EN1];
    assign tick      = run & (presc == PLAST);
    assign wr_status = wr & (off == OFF_STATUS);
    assign clr0      = int_a[IRQ0] | (wr_status & wdata[STAT_PEND0]);
    assign clr1      = int_a[IRQ1] | (wr_status & wdata[STAT_PEND1]);

    // Only the two owned acknowledge bits matter.
    assign unused_bits = ^int_a;

    contador_recarga u_t0 (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .en        (ctrl[CTRL_EN0]),
        .wr_count  (wr & (off == OFF_COUNT0)),
        .wr_reload (wr & (off == OFF_RELOAD0)),
        .clr_pend  (clr0),
        .wdata     (wdata),
        .count     (count0),
        .reload    (reload0),
        .pend      (pend0),
        .pend_d    (pend0_d),
        .expire    (exp0)
    );

    contador_recarga u_t1 (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .en        (ctrl[CTRL_EN1]),
        .wr_count  (wr & (off == OFF_COUNT1)),
        .wr_reload (wr & (off == OFF_RELOAD1)),
        .clr_pend  (clr1),
        .wdata     (wdata),
        .count     (count1),
        .reload    (reload1),
        .pend      (pend1),
        .pend_d    (pend1_d),
        .expire    (exp1)
    );

    always_comb begin
        ctrl_d = ctrl;
        if (exp0 && reload0 == 16'd0) begin
            ctrl_d[CTRL_EN0] = 1'b0;
        end
        if (exp1 && reload1 == 16'd0) begin
            ctrl_d[CTRL_EN1] = 1'b0;
        end
        if (wr && off == OFF_CTRL) begin
            ctrl_d = wdata[CTRL_W-1:0];
        end
        irq_d       = '0;
        irq_d[IRQ0] = pend0_d & ctrl_d[CTRL_IE0];
        irq_d[IRQ1] = pend1_d & ctrl_d[CTRL_IE1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            presc <= '0;
            ctrl  <= '0;
            irq   <= '0;
        end else begin
            ctrl <= ctrl_d;
            irq  <= irq_d;
            if (!run || presc == PLAST) begin
                presc <= '0;
            end else begin
                presc <= presc + PW'(1);
            end
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (off)
                OFF_CTRL:    rdata = {12'd0, ctrl};
                OFF_STATUS:  rdata = {14'd0, pend1, pend0};
                OFF_RELOAD0: rdata = reload0;
                OFF_COUNT0:  rdata = count0;
                OFF_RELOAD1: rdata = reload1;
                OFF_COUNT1:  rdata = count1;
                default:     rdata = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_temporizador_irq.sv
// Directed bench for temporizador_irq: reset, periodic, ack race,
// one-shot with mask, write priority and address decode.
module tb_temporizador_irq;

    localparam logic [15:0] BASE = 16'hFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] direcciones;
    logic [15:0] wdata;
    logic        we;
    logic [15:0] rdata;
    logic        sel;
    logic [7:0]  int_a;
    logic [7:0]  irq;

    int total = 0;
    int bad = 0;

    temporizador_irq #(
        .BASE  (BASE),
        .PRESC (8),
        .IRQ0  (0),
        .IRQ1  (1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .direcciones (direcciones),
        .wdata       (wdata),
        .we          (we),
        .rdata       (rdata),
        .sel         (sel),
        .int_a       (int_a),
        .irq         (irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        direcciones = a;
        wdata = d;
        we = 1'b1;
        @(negedge clk);
        we = 1'b0;
        wdata = '0;
    endtask

    task automatic rd(input logic [15:0] a, output logic [15:0] d);
        direcciones = a;
        #1;
        d = rdata;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        logic [15:0] v;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        total++;
        if (irq !== 8'h00) begin
            bad++;
            $display("FAIL reset_irq got=%h want=00", irq);
        end
        rd(BASE + 16'd0, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL reset_ctrl got=%h want=0000", v);
        end
        rd(BASE + 16'd1, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL reset_status got=%h want=0000", v);
        end
        rd(BASE + 16'd3, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL reset_count0 got=%h want=0000", v);
        end
        direcciones = 16'h0000;
        #1;
        total++;
        if (sel !== 1'b0) begin
            bad++;
            $display("FAIL reset_sel got=%b want=0", sel);
        end
    endtask

    task automatic test_periodic_and_race();
        logic [15:0] v;
        do_reset();
        wr(BASE + 16'd2, 16'd3);
        wr(BASE + 16'd3, 16'd3);
        wr(BASE + 16'd0, 16'h0005);
        rd(BASE + 16'd3, v);
        total++;
        if (v !== 16'd3) begin
            bad++;
            $display("FAIL per_cnt_k0 got=%0d want=3", v);
        end
        for (int k = 1; k <= 66; k++) begin
            @(negedge clk);
            if (k == 8 || k == 16 || k == 24) begin
                rd(BASE + 16'd3, v);
                total++;
                if (v !== 16'(3 - k / 8)) begin
                    bad++;
                    $display("FAIL per_cnt_k%0d got=%0d want=%0d",
                             k, v, 3 - k / 8);
                end
            end
            if (k == 31 || k == 63) begin
                total++;
                if (irq !== 8'h00) begin
                    bad++;
                    $display("FAIL per_early_k%0d got=%h want=00", k, irq);
                end
            end
            if (k == 32) begin
                total++;
                if (irq !== 8'h01) begin
                    bad++;
                    $display("FAIL per_first_irq got=%h want=01", irq);
                end
                rd(BASE + 16'd3, v);
                total++;
                if (v !== 16'd3) begin
                    bad++;
                    $display("FAIL per_reload got=%0d want=3", v);
                end
            end
            if (k == 32 || k == 63 || k == 64) begin
                int_a = 8'h01;
            end
            if (k == 33 || k == 65) begin
                int_a = 8'h00;
                total++;
                if (irq !== 8'h00) begin
                    bad++;
                    $display("FAIL ack_clear_k%0d got=%h want=00", k, irq);
                end
            end
            if (k == 64) begin
                total++;
                if (irq !== 8'h01) begin
                    bad++;
                    $display("FAIL race_irq got=%h want=01", irq);
                end
                rd(BASE + 16'd1, v);
                total++;
                if (v !== 16'h0001) begin
                    bad++;
                    $display("FAIL race_pend got=%h want=0001", v);
                end
            end
        end
        wr(BASE + 16'd0, 16'h0000);
    endtask

    task automatic test_oneshot_mask();
        logic [15:0] v;
        do_reset();
        wr(BASE + 16'd4, 16'd0);
        wr(BASE + 16'd5, 16'd2);
        wr(BASE + 16'd0, 16'h0002);
        repeat (23) @(negedge clk);
        rd(BASE + 16'd1, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL os_early got=%h want=0000", v);
        end
        @(negedge clk);
        rd(BASE + 16'd1, v);
        total++;
        if (v !== 16'h0002) begin
            bad++;
            $display("FAIL os_pend got=%h want=0002", v);
        end
        total++;
        if (irq !== 8'h00) begin
            bad++;
            $display("FAIL os_masked got=%h want=00", irq);
        end
        rd(BASE + 16'd0, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL os_autoclr got=%h want=0000", v);
        end
        wr(BASE + 16'd0, 16'h0008);
        total++;
        if (irq !== 8'h02) begin
            bad++;
            $display("FAIL os_unmask got=%h want=02", irq);
        end
        do_reset();
        @(negedge clk);
        total++;
        if (irq !== 8'h00) begin
            bad++;
            $display("FAIL os_reset_irq got=%h want=00", irq);
        end
        rd(BASE + 16'd1, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL os_reset_pend got=%h want=0000", v);
        end
    endtask

    task automatic test_write_wins();
        logic [15:0] v;
        do_reset();
        wr(BASE + 16'd3, 16'd5);
        wr(BASE + 16'd0, 16'h0001);
        repeat (7) @(negedge clk);
        wr(BASE + 16'd3, 16'd100);
        rd(BASE + 16'd3, v);
        total++;
        if (v !== 16'd100) begin
            bad++;
            $display("FAIL ww_count got=%0d want=100", v);
        end
        wr(BASE + 16'd3, 16'd0);
        repeat (7) @(negedge clk);
        rd(BASE + 16'd1, v);
        total++;
        if (v !== 16'h0001) begin
            bad++;
            $display("FAIL ww_pend got=%h want=0001", v);
        end
        rd(BASE + 16'd0, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL ww_autoclr got=%h want=0000", v);
        end
        wr(BASE + 16'd1, 16'h0001);
        rd(BASE + 16'd1, v);
        total++;
        if (v !== 16'h0000) begin
            bad++;
            $display("FAIL ww_w1c got=%h want=0000", v);
        end
    endtask

    task automatic test_decode();
        logic [15:0] v;
        do_reset();
        wr(BASE + 16'd2, 16'h1234);
        wr(BASE + 16'd6, 16'hFFFF);
        wr(BASE + 16'd7, 16'hFFFF);
        wr(BASE + 16'd8, 16'hFFFF);
        wr(BASE + 16'd0, 16'hFFF0);
        for (int i = 0; i < 9; i++) begin
            rd(BASE + 16'(i), v);
            total++;
            if (v !== ((i == 2) ? 16'h1234 : 16'h0000)) begin
                bad++;
                $display("FAIL dec_rd_off%0d got=%h want=%h", i, v,
                         (i == 2) ? 16'h1234 : 16'h0000);
            end
            total++;
            if (sel !== (i < 8)) begin
                bad++;
                $display("FAIL dec_sel_off%0d got=%b want=%b", i, sel, i < 8);
            end
        end
    endtask

    initial begin
        reset = 1'b0;
        direcciones = '0;
        wdata = '0;
        we = 1'b0;
        int_a = '0;
        test_reset();
        test_periodic_and_race();
        test_oneshot_mask();
        test_write_wins();
        test_decode();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
